// File: rtl/mult_stream_ctrl_pkg.sv
// Shared encodings for the streaming multiplier controller:
// operand modes, controller states and operand width lookup.
package mult_pkg;

  localparam logic [1:0] MODE_U8  = 2'd0;
  localparam logic [1:0] MODE_S8  = 2'd1;
  localparam logic [1:0] MODE_S16 = 2'd2;
  localparam logic [1:0] MODE_SW  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_A,
    S_FETCH_B,
    S_LOAD,
    S_MUL,
    S_FIX,
    S_OUT,
    S_DONE
  } state_e;

  function automatic int unsigned opw_of(
    input logic [1:0]  m,
    input int unsigned dw
  );
    int unsigned w;
    unique case (m)
      MODE_U8:  w = 8;
      MODE_S8:  w = 8;
      MODE_S16: w = 16;
      default:  w = dw;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/mult_stream_ctrl_if.sv
// Product stream bundle: valid/ready handshake with
// product payload and its index within the run.
interface mult_stream_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);

  logic                  prod_valid;
  logic                  prod_ready;
  logic [2*DATA_W-1:0]   product;
  logic [ADDR_W-1:0]     prod_index;

  modport master (
    output prod_valid,
    output product,
    output prod_index,
    input  prod_ready
  );

  modport slave (
    input  prod_valid,
    input  product,
    input  prod_index,
    output prod_ready
  );

endinterface

// File: rtl/mult_stream_ctrl_core.sv
// Sequential shift-add multiplier on operand magnitudes;
// one multiplier bit per step, sign applied on the output.
module seq_mult_core #(
  parameter int DATA_W = 32,
  parameter int CW     = 6
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                load,
  input  logic                step,
  input  logic [CW-1:0]       opw,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  input  logic                neg,
  output logic                last,
  output logic [2*DATA_W-1:0] acc
);

  localparam int PW = 2 * DATA_W;

  logic [PW-1:0]     acc_q, acc_d;
  logic [PW-1:0]     mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              neg_q, neg_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
    end
  end

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    if (load) begin
      acc_d    = '0;
      mcand_d  = PW'(a);
      mplier_d = b;
      cnt_d    = opw;
      neg_d    = neg;
    end else if (step) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CW'(1);
    end
  end

  assign last = (cnt_q == CW'(1));
  assign acc  = neg_q ? -acc_q : acc_q;

endmodule

// File: rtl/mult_stream_ctrl.sv
// Run controller: operand RAM, fetch/multiply/stream FSM
// and the product valid/ready output.
module mult_stream_ctrl
  import mult_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] pair_count,
  input  logic [1:0]        mode,
  output logic              busy,
  output logic              done,
  mult_stream_ctrl_if.master prod
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam int PW = 2 * DATA_W;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [1:0]        mode_q, mode_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              valid_q, valid_d;
  logic [PW-1:0]     prod_q, prod_d;
  logic [ADDR_W-1:0] pidx_q, pidx_d;

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rd_q;
  logic [ADDR_W-1:0] rd_addr;

  logic [DATA_W-1:0] ext_a, ext_b;
  logic [DATA_W-1:0] mag_a, mag_b;
  logic              neg;
  logic              core_load, core_step, core_last;
  logic [CW-1:0]     opw;
  logic [PW-1:0]     core_acc;

  function automatic logic [DATA_W-1:0] sext(
    input logic [DATA_W-1:0] x,
    input logic [1:0]        m
  );
    logic [DATA_W-1:0] r;
    unique case (m)
      MODE_U8:  r = DATA_W'(x[7:0]);
      MODE_S8:  r = DATA_W'($signed(x[7:0]));
      MODE_S16: r = DATA_W'($signed(x[15:0]));
      default:  r = x;
    endcase
    return r;
  endfunction

  // read-before-write: a same-address read sees the old word
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_q <= mem[rd_addr];
  end

  assign ext_a = sext(a_q, mode_q);
  assign ext_b = sext(rd_q, mode_q);
  assign mag_a = ext_a[DATA_W-1] ? -ext_a : ext_a;
  assign mag_b = ext_b[DATA_W-1] ? -ext_b : ext_b;
  assign neg   = ext_a[DATA_W-1] ^ ext_b[DATA_W-1];
  assign opw   = CW'(opw_of(mode_q, DATA_W));

  seq_mult_core #(
    .DATA_W (DATA_W),
    .CW     (CW)
  ) u_core (
    .clock (clock),
    .reset (reset),
    .load  (core_load),
    .step  (core_step),
    .opw   (opw),
    .a     (mag_a),
    .b     (mag_b),
    .neg   (neg),
    .last  (core_last),
    .acc   (core_acc)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      idx_q   <= '0;
      mode_q  <= MODE_U8;
      a_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      prod_q  <= '0;
      pidx_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
      a_q     <= a_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      prod_q  <= prod_d;
      pidx_q  <= pidx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    rem_d     = rem_q;
    idx_d     = idx_q;
    mode_d    = mode_q;
    a_d       = a_q;
    valid_d   = valid_q;
    prod_d    = prod_q;
    pidx_d    = pidx_q;
    rd_addr   = ptr_q;
    core_load = 1'b0;
    core_step = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          ptr_d   = base_addr;
          rem_d   = pair_count;
          mode_d  = mode;
          idx_d   = '0;
          state_d = (pair_count == '0) ? S_DONE : S_FETCH_A;
        end
      end
      S_FETCH_A: begin
        rd_addr = ptr_q;
        state_d = S_FETCH_B;
      end
      S_FETCH_B: begin
        rd_addr = ptr_q + ADDR_W'(1);
        a_d     = rd_q;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        core_load = 1'b1;
        state_d   = S_MUL;
      end
      S_MUL: begin
        core_step = 1'b1;
        if (core_last) state_d = S_FIX;
      end
      S_FIX: begin
        prod_d  = core_acc;
        pidx_d  = idx_q;
        valid_d = 1'b1;
        state_d = S_OUT;
      end
      S_OUT: begin
        if (prod.prod_ready) begin
          valid_d = 1'b0;
          rem_d   = rem_q - ADDR_W'(1);
          ptr_d   = ptr_q + ADDR_W'(2);
          idx_d   = idx_q + ADDR_W'(1);
          state_d = (rem_q == ADDR_W'(1)) ? S_DONE : S_FETCH_A;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign prod.prod_valid = valid_q;
  assign prod.product    = prod_q;
  assign prod.prod_index = pidx_q;

endmodule

// File: doc/mult_stream_ctrl.md
Name: mult_stream_ctrl

Overview:
Parametrised, iterative successor to the fixed-width multiplier controller. It owns an internal operand RAM and, on a start command, walks a run of consecutive operand pairs. Each pair is multiplied with a shared shift-add datapath in one of four width/sign modes, and each product is streamed out on a valid/ready interface. It replaces the four parallel combinational multipliers with one sequential core, and adds run control, backpressure and a completion pulse.

Parameters:
DATA_W, 32, operand RAM word width and widest multiplier mode (≥16, even)
ADDR_W, 5, operand RAM address width; depth = 2**ADDR_W

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
wr_en  in  1  operand RAM write strobe
wr_addr  in  ADDR_W  operand RAM write address
wr_data  in  DATA_W  operand RAM write data
start  in  1  run request; sampled only in IDLE
base_addr  in  ADDR_W  address of first operand A of the run
pair_count  in  ADDR_W  number of pairs in the run
mode  in  2  0=unsigned 8, 1=signed 8, 2=signed 16, 3=signed DATA_W
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at end of run
prod_valid  out  1  product available
prod_ready  in  1  consumer accepts product
product  out  2*DATA_W  result, sign-extended (modes 1-3) or zero-extended (mode 0)
prod_index  out  ADDR_W  0-based index of the pair within the run

Behaviour:
- Reset: busy=0, done=0, prod_valid=0, product=0, prod_index=0, FSM=IDLE. RAM contents are not reset.
- RAM: one write port and one synchronous read port (data appears the cycle after the address is driven).
  - A write and a read to the same address in the same cycle: the read returns the old data.
  - Writes are allowed while busy.
- Operand width opw = 8, 8, 16, DATA_W for modes 0..3. Each operand is the low opw bits of its word.
  - In signed modes the operand is treated as two's complement. In mode 0 it is unsigned.
- FSM states: IDLE, FETCH_A, FETCH_B, LOAD, MUL, FIX, OUT, DONE.
- IDLE:
  - On start=1, latch base_addr into ptr, pair_count into remaining, and mode. Set busy=1 and go to FETCH_A.
  - If pair_count=0, go straight to DONE instead.
- FETCH_A: drive read addr = ptr.
- FETCH_B: capture A; drive read addr = ptr+1, which wraps modulo 2**ADDR_W.
- LOAD:
  - Capture B.
  - Form |A| and |B|, and neg = sign(A) XOR sign(B) (neg=0 in mode 0).
  - Clear the accumulator and set bit counter = opw.
- MUL: one multiplier bit per cycle (shift-add), opw cycles.
- FIX:
  - product = neg ? −acc : acc, extended to 2*DATA_W.
  - Drive prod_index = run pair number.
- OUT:
  - prod_valid=1; product and prod_index are held stable until prod_valid&&prod_ready.
  - On that handshake: remaining−1 and ptr+2 (wraps).
  - If pairs remain, go to FETCH_A; otherwise go to DONE.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE. A start presented in the DONE cycle is ignored.
- Latency: with start sampled at edge k, prod_valid rises after edge k+opw+4. Each later pair's prod_valid rises opw+4 edges after the previous handshake.
- start, mode, base_addr and pair_count are ignored while busy. The run uses its latched values.
- prod_ready has no effect outside OUT. prod_valid never drops without a handshake except on reset.
- Overflow: none possible, because the full 2*opw-bit product always fits in 2*DATA_W.
- Asserting reset mid-run aborts the run immediately: outputs return to reset values and no done pulse is issued.

Decomposition:
- Package mult_pkg holds:
  - mode encodings MODE_U8, MODE_S8, MODE_S16, MODE_SW;
  - FSM state enumeration;
  - function opw_of(mode).
- Sub-module seq_mult_core (shift-add datapath: load, step, bit counter, sign fix; ports load/step/last, a, b, neg, acc). The controller keeps the FSM, RAM and stream interface.

Test Plan:
- Mode 0, RAM[0]=0xFF, RAM[1]=0xFF, pair_count=1, prod_ready=1 -> product=0xFE01, prod_valid after edge k+12, done pulse one cycle after the handshake.
- Mode 1, RAM[2]=0x80, RAM[3]=0x7F -> product=0xFFFF_FFFF_FFFF_C080 (−16256). Mode 2, words 0x7FFF and 0xFFFF -> 0xFFFF_FFFF_FFFF_8001.
- Mode 3, both operands 0x8000_0000 -> 0x4000_0000_0000_0000. Both operands 0xFFFF_FFFF -> product 1.
- Run base_addr=30, pair_count=2 -> pairs (30,31) then (0,1) via wrap; prod_index 0 then 1. Hold prod_ready=0 for 5 cycles -> product stable, no extra products, busy stays 1.
- pair_count=0 -> done pulse, no prod_valid. A start while busy, and a mode change mid-run -> ignored.
- Assert reset during MUL -> busy=0, prod_valid=0, no done. A new start after release completes a correct run.
